// File: rtl/mem_dma_copy_pkg.sv
// Shared bus-master definitions: FSM encoding, write-strobe codes and word alignment.
package mem_dma_copy_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_RD     = 3'd1,
        S_RD_GAP = 3'd2,
        S_WR     = 3'd3,
        S_WR_GAP = 3'd4,
        S_FIN    = 3'd5
    } state_t;

    localparam logic [3:0]  WSTRB_NONE = 4'b0000;
    localparam logic [3:0]  WSTRB_WORD = 4'b1111;
    localparam logic [31:0] WORD_MASK  = 32'hFFFF_FFFC;

endpackage

// File: rtl/mem_req_timeout.sv
// Request watchdog: counts stalled cycles of an outstanding bus request.
// o_expired rises once the counter has reached TIMEOUT-1; it then holds until cleared.
module mem_req_timeout #(
    parameter int TIMEOUT = 1024
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clr,
    input  logic i_en,
    output logic o_expired
);

    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

    logic [CW-1:0] r_cnt;
    logic          w_expired;

    assign w_expired = (r_cnt == LAST);
    assign o_expired = w_expired;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !w_expired) begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/mem_dma_copy.sv
// Word-by-word memory copy engine on the valid-ready bus: one read then one write per word,
// with a one-cycle valid gap after every handshake so responders see a fresh rising edge.
module mem_dma_copy
    import mem_dma_copy_pkg::*;
#(
    parameter int LEN_WIDTH = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic [31:0]          src_addr,
    input  logic [31:0]          dst_addr,
    input  logic [LEN_WIDTH-1:0] len_words,
    input  logic                 abort,
    output logic                 busy,
    output logic                 done,
    output logic                 err,
    output logic [LEN_WIDTH-1:0] words_done,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic [31:0]          mem_addr,
    output logic [31:0]          mem_wdata,
    output logic [3:0]           mem_wstrb,
    input  logic [31:0]          mem_rdata
);

    state_t               r_state;
    logic [31:0]          r_src;
    logic [31:0]          r_dst;
    logic [31:0]          r_buf;
    logic [LEN_WIDTH-1:0] r_remain;
    logic [LEN_WIDTH-1:0] r_words_done;
    logic                 r_abort_pend;
    logic                 r_busy;
    logic                 r_done;
    logic                 r_err;
    logic                 r_mem_valid;
    logic [31:0]          r_mem_addr;
    logic [31:0]          r_mem_wdata;
    logic [3:0]           r_mem_wstrb;
    logic                 w_expired;

    // The watchdog restarts whenever valid is low, i.e. in every gap before RD/WR.
    mem_req_timeout #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (~r_mem_valid),
        .i_en      (r_mem_valid & ~mem_ready),
        .o_expired (w_expired)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_src        <= '0;
            r_dst        <= '0;
            r_buf        <= '0;
            r_remain     <= '0;
            r_words_done <= '0;
            r_abort_pend <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
            r_mem_valid  <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wstrb  <= '0;
        end else begin
            r_done <= 1'b0;
            if (abort && r_busy) begin
                r_abort_pend <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_src        <= src_addr & WORD_MASK;
                        r_dst        <= dst_addr & WORD_MASK;
                        r_remain     <= len_words;
                        r_err        <= 1'b0;
                        r_words_done <= '0;
                        r_abort_pend <= 1'b0;
                        if (len_words == '0) begin
                            r_state <= S_FIN;
                            r_done  <= 1'b1;
                        end else begin
                            r_state     <= S_RD;
                            r_busy      <= 1'b1;
                            r_mem_valid <= 1'b1;
                            r_mem_addr  <= src_addr & WORD_MASK;
                            r_mem_wstrb <= WSTRB_NONE;
                        end
                    end
                end
                S_RD: begin
                    if (mem_ready) begin
                        r_buf       <= mem_rdata;
                        r_mem_valid <= 1'b0;
                        r_state     <= S_RD_GAP;
                    end else if (w_expired) begin
                        r_mem_valid <= 1'b0;
                        r_err       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_FIN;
                    end
                end
                S_RD_GAP: begin
                    r_mem_valid <= 1'b1;
                    r_mem_addr  <= r_dst;
                    r_mem_wdata <= r_buf;
                    r_mem_wstrb <= WSTRB_WORD;
                    r_state     <= S_WR;
                end
                S_WR: begin
                    if (mem_ready) begin
                        r_words_done <= r_words_done + LEN_WIDTH'(1);
                        r_src        <= r_src + 32'd4;
                        r_dst        <= r_dst + 32'd4;
                        r_remain     <= r_remain - LEN_WIDTH'(1);
                        r_mem_valid  <= 1'b0;
                        r_state      <= S_WR_GAP;
                    end else if (w_expired) begin
                        r_mem_valid <= 1'b0;
                        r_err       <= 1'b1;
                        r_busy      <= 1'b0;
                        r_done      <= 1'b1;
                        r_state     <= S_FIN;
                    end
                end
                S_WR_GAP: begin
                    // Abort is honoured only here so a word already read is always written.
                    if (r_remain == '0 || r_abort_pend || abort) begin
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                        r_state <= S_FIN;
                    end else begin
                        r_mem_valid <= 1'b1;
                        r_mem_addr  <= r_src;
                        r_mem_wstrb <= WSTRB_NONE;
                        r_state     <= S_RD;
                    end
                end
                S_FIN: begin
                    r_abort_pend <= 1'b0;
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign err        = r_err;
    assign words_done = r_words_done;
    assign mem_valid  = r_mem_valid;
    assign mem_addr   = r_mem_addr;
    assign mem_wdata  = r_mem_wdata;
    assign mem_wstrb  = r_mem_wstrb;

endmodule

// File: tb/tb_mem_dma_copy.sv
// Directed-plus-random bench for mem_dma_copy against a RAM responder and a transaction-list model.
module tb_mem_dma_copy;

    localparam int LW = 16;
    localparam int TO = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [31:0]   src_addr;
    logic [31:0]   dst_addr;
    logic [LW-1:0] len_words;
    logic          abort;
    logic          busy;
    logic          done;
    logic          err;
    logic [LW-1:0] words_done;
    logic          mem_valid;
    logic          mem_ready;
    logic [31:0]   mem_addr;
    logic [31:0]   mem_wdata;
    logic [3:0]    mem_wstrb;
    logic [31:0]   mem_rdata;

    always #5 clk = ~clk;

    mem_dma_copy #(.LEN_WIDTH(LW), .TIMEOUT(TO)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .src_addr   (src_addr),
        .dst_addr   (dst_addr),
        .len_words  (len_words),
        .abort      (abort),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .words_done (words_done),
        .mem_valid  (mem_valid),
        .mem_ready  (mem_ready),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_wstrb  (mem_wstrb),
        .mem_rdata  (mem_rdata)
    );

    typedef struct packed {
        logic        wr;
        logic [31:0] addr;
        logic [31:0] data;
    } xact_t;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    xact_t       log_q[$];
    xact_t       exp_q[$];
    logic [31:0] ram [logic [31:0]];

    int  fixed_lat   = 1;
    bit  spurious    = 1'b0;
    bit  never_ready = 1'b0;
    bit  hs          = 1'b0;
    int  cnt         = 0;
    int  cur_lat     = 0;
    int  gap_viol, stab_viol, valid_run, valid_run_max, valid_cycles;
    bit  busy_seen;
    logic        prev_valid = 1'b0;
    logic [31:0] prev_addr, prev_wdata;
    logic [3:0]  prev_wstrb;

    always @(posedge clk) cyc++;

    function automatic logic [31:0] ram_rd(input logic [31:0] a);
        return ram.exists(a) ? ram[a] : (a ^ 32'hA5A5_5A5A);
    endfunction

    // RAM responder plus protocol monitor, all evaluated mid-cycle.
    always @(negedge clk) begin
        if (mem_valid === 1'b1) valid_cycles++;
        valid_run = (mem_valid === 1'b1) ? valid_run + 1 : 0;
        if (valid_run > valid_run_max) valid_run_max = valid_run;
        if (busy === 1'b1) busy_seen = 1'b1;
        if (prev_valid && mem_valid === 1'b1 && !hs &&
            (mem_addr !== prev_addr || mem_wdata !== prev_wdata || mem_wstrb !== prev_wstrb))
            stab_viol++;
        if (hs && mem_valid === 1'b1) gap_viol++;
        prev_valid = (mem_valid === 1'b1);
        prev_addr  = mem_addr;
        prev_wdata = mem_wdata;
        prev_wstrb = mem_wstrb;
        if (rst) begin
            mem_ready = 1'b0; hs = 1'b0; cnt = 0;
        end else if (hs) begin
            mem_ready = 1'b0; hs = 1'b0; cnt = 0;
        end else if (mem_valid !== 1'b1) begin
            mem_ready = spurious ? 1'($urandom_range(0, 1)) : 1'b0;
            mem_rdata = $urandom;
            cnt       = 0;
            cur_lat   = (fixed_lat < 0) ? int'($urandom_range(0, 3)) : fixed_lat;
        end else if (never_ready || cnt < cur_lat) begin
            mem_ready = 1'b0;
            mem_rdata = $urandom;
            cnt++;
        end else begin
            mem_ready = 1'b1;
            hs        = 1'b1;
            if (mem_wstrb == 4'hF) begin
                ram[mem_addr] = mem_wdata;
                log_q.push_back({1'b1, mem_addr, mem_wdata});
            end else begin
                mem_rdata = ram_rd(mem_addr);
                log_q.push_back({1'b0, mem_addr, mem_rdata});
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic reset_mon();
        gap_viol = 0; stab_viol = 0; valid_run_max = 0; valid_cycles = 0;
        busy_seen = 1'b0;
        log_q.delete();
    endtask

    // Reference: word i reads (src&~3)+4i then writes the same data to (dst&~3)+4i.
    task automatic build_exp(input logic [31:0] s, input logic [31:0] d, input int n);
        logic [31:0] sa, da, v;
        exp_q.delete();
        sa = s & ~32'd3;
        da = d & ~32'd3;
        for (int i = 0; i < n; i++) begin
            v = ram_rd(sa);
            exp_q.push_back({1'b0, sa, v});
            exp_q.push_back({1'b1, da, v});
            sa = sa + 32'd4;
            da = da + 32'd4;
        end
    endtask

    task automatic check_log();
        check("xact_count", log_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
            check("xact_kind", {31'd0, log_q[i].wr}, {31'd0, exp_q[i].wr});
            check("xact_addr", log_q[i].addr, exp_q[i].addr);
            check("xact_data", log_q[i].data, exp_q[i].data);
        end
        for (int i = 0; i < exp_q.size(); i++)
            if (exp_q[i].wr) check("dst_word", ram_rd(exp_q[i].addr), exp_q[i].data);
        check("valid_gap", gap_viol, 0);
        check("hold_stable", stab_viol, 0);
    endtask

    task automatic kick(input logic [31:0] s, input logic [31:0] d, input int n, output int x);
        @(negedge clk);
        src_addr  = s;
        dst_addr  = d;
        len_words = LW'(n);
        start     = 1'b1;
        x         = cyc;
        @(negedge clk);
        start     = 1'b0;
    endtask

    task automatic wait_done(input int x, output int off);
        bit found = 1'b0;
        off = -1;
        for (int i = 0; i < 3000; i++) begin
            if (done === 1'b1) begin
                found = 1'b1;
                off   = cyc - x;
                break;
            end
            @(negedge clk);
        end
        check("done_seen", {31'd0, found}, 32'd1);
    endtask

    initial begin
        int x, off, n;
        logic [31:0] s, d;
        bit found;
        rst = 1'b1; start = 1'b0; abort = 1'b0;
        src_addr = '0; dst_addr = '0; len_words = '0;
        mem_ready = 1'b0; mem_rdata = '0;
        repeat (3) @(negedge clk);
        check("rst_ctrl", {28'd0, busy, done, err, mem_valid}, 32'd0);
        check("rst_words_done", {16'd0, words_done}, 32'd0);
        check("rst_addr", mem_addr, 32'd0);
        check("rst_wdata", mem_wdata, 32'd0);
        check("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        rst = 1'b0;

        // 4-word directed copy, ready one cycle after valid.
        for (int i = 0; i < 4; i++) ram[32'h100 + 4*i] = 32'h1111_1111 * (i + 1);
        fixed_lat = 1; spurious = 1'b0;
        reset_mon();
        build_exp(32'h100, 32'h200, 4);
        kick(32'h100, 32'h200, 4, x);
        check("busy_after_start", {31'd0, busy}, 32'd1);
        wait_done(x, off);
        check("done_latency_4w", off, 25);
        check("words_done_4w", {16'd0, words_done}, 32'd4);
        check("err_4w", {31'd0, err}, 32'd0);
        check_log();
        @(negedge clk);
        check("done_pulse_1cyc", {30'd0, done, busy}, 32'd0);

        // Random copies with random latency and stray ready while idle.
        fixed_lat = -1; spurious = 1'b1;
        for (int t = 0; t < 4; t++) begin
            n = $urandom_range(1, 8);
            s = 32'h1000_0000 + ($urandom_range(0, 255) << 4) + $urandom_range(0, 3);
            d = 32'h2000_0000 + ($urandom_range(0, 255) << 4) + $urandom_range(0, 3);
            reset_mon();
            build_exp(s, d, n);
            kick(s, d, n, x);
            wait_done(x, off);
            check("words_done_rand", {16'd0, words_done}, n);
            check("err_rand", {31'd0, err}, 32'd0);
            check_log();
        end
        spurious = 1'b0; fixed_lat = 1;

        // Zero-length copy.
        reset_mon();
        kick(32'h400, 32'h500, 0, x);
        wait_done(x, off);
        check("len0_done_early", {31'd0, (off >= 1 && off <= 2)}, 32'd1);
        repeat (2) @(negedge clk);
        check("len0_no_valid", valid_cycles, 0);
        check("len0_busy_low", {31'd0, busy_seen}, 32'd0);

        // Timeout with a responder that never answers.
        never_ready = 1'b1;
        reset_mon();
        kick(32'h600, 32'h700, 3, x);
        wait_done(x, off);
        check("timeout_valid_run", valid_run_max, TO);
        check("timeout_err", {31'd0, err}, 32'd1);
        check("timeout_words", {16'd0, words_done}, 32'd0);
        never_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("err_sticky", {31'd0, err}, 32'd1);
        check("timeout_no_xact", log_q.size(), 0);
        reset_mon();
        build_exp(32'h800, 32'h900, 1);
        kick(32'h800, 32'h900, 1, x);
        check("err_cleared_by_start", {31'd0, err}, 32'd0);
        wait_done(x, off);
        check_log();

        // Abort during the read of word 2 of 5.
        reset_mon();
        build_exp(32'hA00, 32'hB00, 2);
        kick(32'hA00, 32'hB00, 5, x);
        found = 1'b0;
        for (int i = 0; i < 200 && !found; i++) begin
            if (log_q.size() == 2 && mem_valid === 1'b1 && mem_wstrb == 4'h0) found = 1'b1;
            else @(negedge clk);
        end
        check("abort_window_seen", {31'd0, found}, 32'd1);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        wait_done(x, off);
        repeat (4) @(negedge clk);
        check("abort_words", {16'd0, words_done}, 32'd2);
        check_log();

        // Source address wrap at the top of the 32-bit space.
        reset_mon();
        build_exp(32'hFFFF_FFF8, 32'h0000_3000, 3);
        kick(32'hFFFF_FFF8, 32'h0000_3000, 3, x);
        wait_done(x, off);
        check("wrap_err", {31'd0, err}, 32'd0);
        check_log();

        // Stray starts while busy and in the FIN cycle are ignored.
        fixed_lat = 2;
        reset_mon();
        build_exp(32'hC00, 32'hD00, 4);
        kick(32'hC00, 32'hD00, 4, x);
        found = 1'b0;
        for (int i = 0; i < 500 && !found; i++) begin
            if (done === 1'b1) found = 1'b1;
            else begin
                start     = 1'($urandom_range(0, 2) == 0);
                src_addr  = 32'hE00;
                len_words = LW'(7);
                @(negedge clk);
            end
        end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        check("fin_start_ignored", {30'd0, busy, mem_valid}, 32'd0);
        check("busy_start_words", {16'd0, words_done}, 32'd4);
        check_log();

        // Asynchronous reset in the middle of a write.
        fixed_lat = 3;
        reset_mon();
        kick(32'hF00, 32'hF80, 3, x);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            if (mem_valid === 1'b1 && mem_wstrb == 4'hF) found = 1'b1;
            else @(negedge clk);
        end
        check("wr_phase_seen", {31'd0, found}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check("async_rst_outs", {30'd0, busy, mem_valid}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_idle", {16'd0, words_done, 13'd0, busy, mem_valid, err}, 32'd0);
        fixed_lat = 1;
        reset_mon();
        build_exp(32'h1F00, 32'h1F80, 2);
        kick(32'h1F00, 32'h1F80, 2, x);
        wait_done(x, off);
        check("post_rst_words", {16'd0, words_done}, 32'd2);
        check_log();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
